// File: rtl/button_repeat_if.sv
// ============================================================================
// Module      : button_repeat_if
// Description : Key-conditioner bus: raw active-low key in, press pulse and
//               hold/repeat level flags out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface button_repeat_if;
   logic signal;
   logic state;
   logic held;
   logic repeating;

   modport master (
      output signal,
      input  state,
      input  held,
      input  repeating
   );

   modport slave (
      input  signal,
      output state,
      output held,
      output repeating
   );
endinterface

`default_nettype wire

// File: rtl/button_repeat.sv
// ============================================================================
// Module      : button_repeat
// Description : Synchronise, debounce and auto-repeat one active-low key.
//               Optional auto-repeat is enabled with BUTTON_AUTO_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_repeat #(
   parameter int unsigned DEBOUNCE_TICKS = 500000,
   parameter int unsigned REPEAT_DELAY   = 25000000,
   parameter int unsigned REPEAT_PERIOD  = 5000000
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   button_repeat_if.slave    bus
);

   localparam int unsigned c_max_ab = (DEBOUNCE_TICKS > REPEAT_DELAY) ? DEBOUNCE_TICKS : REPEAT_DELAY;
   localparam int unsigned c_max    = (c_max_ab > REPEAT_PERIOD) ? c_max_ab : REPEAT_PERIOD;
   localparam int unsigned CW       = $clog2(c_max);

   localparam logic [CW-1:0] c_db_last = CW'(DEBOUNCE_TICKS - 1);
`ifdef BUTTON_AUTO_REPEAT_EN
   localparam logic [CW-1:0] c_delay_last  = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] c_period_last = CW'(REPEAT_PERIOD - 1);
`endif

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_PRESS_DB   = 3'd1,
      ST_HELD       = 3'd2,
`ifdef BUTTON_AUTO_REPEAT_EN
      ST_REPEAT     = 3'd3,
`endif
      ST_RELEASE_DB = 3'd4
   } state_e;

   logic [1:0]    sync_q;
   logic          pressed;
   state_e        fsm_q, fsm_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pulse_q, pulse_d;
   logic          state_q;
   logic          held_q;
   logic          repeating_q;

   // Two-flop synchroniser on the inverted key so 1 means pressed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], ~bus.signal};
      end
   end

   assign pressed = sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q   <= ST_IDLE;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   // Release is tested first in every state so it beats a terminal count
   always_comb begin
      fsm_d   = fsm_q;
      cnt_d   = '0;
      pulse_d = 1'b0;
      case (fsm_q)
         ST_IDLE: begin
            if (pressed) begin
               fsm_d = ST_PRESS_DB;
            end
         end
         ST_PRESS_DB: begin
            if (!pressed) begin
               fsm_d = ST_IDLE;
            end else if (cnt_q == c_db_last) begin
               fsm_d   = ST_HELD;
               pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_HELD: begin
            if (!pressed) begin
               fsm_d = ST_RELEASE_DB;
`ifdef BUTTON_AUTO_REPEAT_EN
            end else if (cnt_q == c_delay_last) begin
               fsm_d   = ST_REPEAT;
               pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
`endif
            end
         end
`ifdef BUTTON_AUTO_REPEAT_EN
         ST_REPEAT: begin
            if (!pressed) begin
               fsm_d = ST_RELEASE_DB;
            end else if (cnt_q == c_period_last) begin
               pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`endif
         ST_RELEASE_DB: begin
            if (pressed) begin
               fsm_d = ST_HELD;
            end else if (cnt_q == c_db_last) begin
               fsm_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            fsm_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= 1'b0;
         held_q      <= 1'b0;
         repeating_q <= 1'b0;
      end else begin
         state_q     <= pulse_q;
         held_q      <= (fsm_q == ST_HELD) || (fsm_q == ST_RELEASE_DB)
`ifdef BUTTON_AUTO_REPEAT_EN
                        || (fsm_q == ST_REPEAT)
`endif
                        ;
`ifdef BUTTON_AUTO_REPEAT_EN
         repeating_q <= (fsm_q == ST_REPEAT);
`else
         repeating_q <= 1'b0;
`endif
      end
   end

   assign bus.state     = state_q;
   assign bus.held      = held_q;
   assign bus.repeating = repeating_q;

endmodule

`default_nettype wire

// File: tb/tb_button_repeat.sv
// ============================================================================
// Module      : tb_button_repeat
// Description : Directed bench for button_repeat with small tick parameters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_repeat;

   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   button_repeat_if bus_if ();

   button_repeat #(
      .DEBOUNCE_TICKS (DB),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   task automatic check(input string tag, input logic obs, input logic exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rng(input int lo, input int hi);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 64; i++) begin
         if (i >= lo && i <= hi) m[i] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic [63:0] bit_at(input int e);
      logic [63:0] m;
      m = '0;
      m[e] = 1'b1;
      return m;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n         = 1'b0;
      bus_if.signal = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   // Bit e of each mask applies to edge e: key/reset level sampled at that
   // edge, and the expected outputs observed just after it.
   task automatic run(input string name, input int n,
                      input logic [63:0] key_m, input logic [63:0] rst_m,
                      input logic [63:0] st_m,  input logic [63:0] hd_m,
                      input logic [63:0] rp_m);
      for (int e = 0; e < n; e++) begin
         @(negedge clk);
         bus_if.signal = ~key_m[e];
         rst_n         = ~rst_m[e];
         if (rst_m[e]) begin
            #1;
            check($sformatf("%s rst state e%0d", name, e), bus_if.state, 1'b0);
            check($sformatf("%s rst held e%0d", name, e), bus_if.held, 1'b0);
            check($sformatf("%s rst rep e%0d", name, e), bus_if.repeating, 1'b0);
         end
         @(posedge clk);
         #1;
         check($sformatf("%s state e%0d", name, e), bus_if.state, st_m[e]);
         check($sformatf("%s held e%0d", name, e), bus_if.held, hd_m[e]);
         check($sformatf("%s rep e%0d", name, e), bus_if.repeating, rp_m[e]);
      end
      bus_if.signal = 1'b1;
      rst_n         = 1'b1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] st_c, rp_c, st_d, rp_d;
      bus_if.signal = 1'b1;
      rst_n         = 1'b0;
      #1;
      check("reset state", bus_if.state, 1'b0);
      check("reset held", bus_if.held, 1'b0);
      check("reset rep", bus_if.repeating, 1'b0);

`ifdef BUTTON_AUTO_REPEAT_EN
      st_c = bit_at(7) | bit_at(17) | bit_at(20) | bit_at(23) | bit_at(26)
           | bit_at(29) | bit_at(32) | bit_at(35) | bit_at(38) | bit_at(41);
      rp_c = rng(17, 42);
      st_d = bit_at(7) | bit_at(26) | bit_at(29) | bit_at(32);
      rp_d = rng(26, 32);
`else
      st_c = bit_at(7);
      rp_c = '0;
      st_d = bit_at(7);
      rp_d = '0;
`endif

      do_reset();
      run("clean", 24, rng(0, 11), '0, bit_at(7), rng(7, 18), '0);

      do_reset();
      run("bounce", 16, 64'h1B, '0, '0, '0, '0);

      do_reset();
      run("hold", 50, rng(0, 39), '0, st_c, rng(7, 46), rp_c);

      do_reset();
      run("glitch", 44, rng(0, 11) | rng(13, 29), '0, st_d, rng(7, 36), rp_d);

      do_reset();
      run("midrst", 30, rng(0, 29), rng(15, 16), bit_at(7) | bit_at(24),
          rng(7, 14) | rng(24, 29), '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
